// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, iterative multiply and optional restoring divide.
// Define ALU_DIV_EN to build the divider (DIVU/REMU); otherwise those opcodes decode as illegal.
module alu_mc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow,
  output logic             DivZero,
  output logic             Illegal
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpLnot  = 4'b0010;
  localparam logic [3:0] OpShl   = 4'b0011;
  localparam logic [3:0] OpShr   = 4'b0100;
  localparam logic [3:0] OpAnd   = 4'b0101;
  localparam logic [3:0] OpOr    = 4'b0110;
  localparam logic [3:0] OpSltu  = 4'b0111;
  localparam logic [3:0] OpMul   = 4'b1000;
  localparam logic [3:0] OpMulhu = 4'b1001;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OpDivu  = 4'b1010;
  localparam logic [3:0] OpRemu  = 4'b1011;
`endif

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     b_q, b_d;
  // MUL: running product. DIV: {partial remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 dz_q, dz_d;
  logic                 ill_q, ill_d;

  logic [WIDTH:0]       sum_ext, diff_ext;
  logic                 big_shift;
  logic                 last_step;

  assign sum_ext   = {1'b0, data_1} + {1'b0, data_2};
  assign diff_ext  = {1'b0, data_1} - {1'b0, data_2};
  assign big_shift = data_2 >= WIDTH'(WIDTH);
  assign last_step = cnt_q == CntW'(WIDTH - 1);

`ifdef ALU_DIV_EN
  logic [WIDTH:0]       rem_sh, rem_trial;
  logic [WIDTH-1:0]     rem_next;
  logic                 q_bit;

  assign rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_trial = rem_sh - {1'b0, b_q};
  assign q_bit     = ~rem_trial[WIDTH];
  assign rem_next  = q_bit ? rem_trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mcand_d = mcand_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    ill_d   = ill_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = ALU_Control;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          ill_d   = 1'b0;
          state_d = StDone;
          case (ALU_Control)
            OpAdd: begin
              res_d   = sum_ext[WIDTH-1:0];
              carry_d = sum_ext[WIDTH];
              ovf_d   = (data_1[WIDTH-1] == data_2[WIDTH-1]) &&
                        (sum_ext[WIDTH-1] != data_1[WIDTH-1]);
            end
            OpSub: begin
              res_d   = diff_ext[WIDTH-1:0];
              carry_d = diff_ext[WIDTH];
              ovf_d   = (data_1[WIDTH-1] != data_2[WIDTH-1]) &&
                        (diff_ext[WIDTH-1] != data_1[WIDTH-1]);
            end
            OpLnot:  res_d = {{(WIDTH-1){1'b0}}, data_1 == '0};
            OpShl:   res_d = big_shift ? '0 : data_1 << data_2;
            OpShr:   res_d = big_shift ? '0 : data_1 >> data_2;
            OpAnd:   res_d = data_1 & data_2;
            OpOr:    res_d = data_1 | data_2;
            OpSltu:  res_d = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
            OpMul, OpMulhu: begin
              mcand_d = {{WIDTH{1'b0}}, data_1};
              b_d     = data_2;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = StMul;
            end
`ifdef ALU_DIV_EN
            OpDivu, OpRemu: begin
              if (data_2 == '0) begin
                res_d = (ALU_Control == OpDivu) ? '1 : data_1;
                dz_d  = 1'b1;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, data_1};
                b_d     = data_2;
                cnt_d   = '0;
                state_d = StDiv;
              end
            end
`endif
            default: begin
              res_d = '0;
              ill_d = 1'b1;
            end
          endcase
        end
      end
      StMul: begin
        acc_d   = acc_q + (b_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (last_step) begin
          res_d   = (op_q == OpMulhu) ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
          state_d = StDone;
        end
      end
`ifdef ALU_DIV_EN
      StDiv: begin
        acc_d = {rem_next, acc_q[WIDTH-2:0], q_bit};
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          res_d   = (op_q == OpDivu) ? acc_d[WIDTH-1:0] : acc_d[2*WIDTH-1:WIDTH];
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Zero tracks the result only when a new result is committed, so reset leaves it at 0.
    if (state_d == StDone && state_q != StDone) zero_d = (res_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      mcand_q <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mcand_q <= mcand_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign ALU_Result = res_q;
  assign Zero       = zero_q;
  assign Carry      = carry_q;
  assign Overflow   = ovf_q;
  assign DivZero    = dz_q;
  assign Illegal    = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=16; adapts the divide vectors to ALU_DIV_EN.
module tb_alu_mc;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALU_Control;
  logic [W-1:0] data_1, data_2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_Result;
  logic         Zero, Carry, Overflow, DivZero, Illegal;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALU_Control(ALU_Control),
    .data_1     (data_1),
    .data_2     (data_2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALU_Result (ALU_Result),
    .Zero       (Zero),
    .Carry      (Carry),
    .Overflow   (Overflow),
    .DivZero    (DivZero),
    .Illegal    (Illegal)
  );

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [4:0]   flags; // {Zero, Carry, Overflow, DivZero, Illegal}
    int           lat;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input string name, input logic [3:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] res,
                              input logic [4:0] flags, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.flags = flags; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Accept on the next edge, scramble inputs, then count edges until out_valid (accept edge = 1).
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1; ALU_Control = op; data_1 = a; data_2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; ALU_Control = 4'hF; data_1 = ~a; data_2 = ~b;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; ALU_Control = '0; data_1 = '0; data_2 = '0; out_ready = 1'b1;

    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(ALU_Result), 32'd0);
    check("reset flags", 32'({Zero, Carry, Overflow, DivZero, Illegal}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //   name           op     a         b         result    ZCVDI     lat
    add("add_wrap",    4'h0, 16'hFFFF, 16'h0001, 16'h0000, 5'b11000, 1);
    add("add_ovf",     4'h0, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100, 1);
    add("sub_ovf",     4'h1, 16'h8000, 16'h0001, 16'h7FFF, 5'b00100, 1);
    add("sub_borrow",  4'h1, 16'h0001, 16'h0002, 16'hFFFF, 5'b01000, 1);
    add("lnot_0",      4'h2, 16'h0000, 16'h1234, 16'h0001, 5'b00000, 1);
    add("lnot_5",      4'h2, 16'h0005, 16'h0000, 16'h0000, 5'b10000, 1);
    add("shl_16",      4'h3, 16'h0001, 16'h0010, 16'h0000, 5'b10000, 1);
    add("shl_4",       4'h3, 16'h0003, 16'h0004, 16'h0030, 5'b00000, 1);
    add("shr_15",      4'h4, 16'h8000, 16'h000F, 16'h0001, 5'b00000, 1);
    add("shr_big",     4'h4, 16'hFFFF, 16'h1000, 16'h0000, 5'b10000, 1);
    add("and",         4'h5, 16'hF0F0, 16'hFF00, 16'hF000, 5'b00000, 1);
    add("or",          4'h6, 16'hF0F0, 16'h0F0F, 16'hFFFF, 5'b00000, 1);
    add("sltu_t",      4'h7, 16'h0003, 16'h0005, 16'h0001, 5'b00000, 1);
    add("sltu_f",      4'h7, 16'h0005, 16'h0003, 16'h0000, 5'b10000, 1);
    add("mul",         4'h8, 16'h1234, 16'h0100, 16'h3400, 5'b00000, 17);
    add("mulhu",       4'h9, 16'h1234, 16'h0100, 16'h0012, 5'b00000, 17);
    add("mul_max",     4'h8, 16'hFFFF, 16'hFFFF, 16'h0001, 5'b00000, 17);
    add("mulhu_max",   4'h9, 16'hFFFF, 16'hFFFF, 16'hFFFE, 5'b00000, 17);
    add("illegal_c",   4'hC, 16'h1111, 16'h2222, 16'h0000, 5'b10001, 1);
    add("illegal_f",   4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b10001, 1);
`ifdef ALU_DIV_EN
    add("divu",        4'hA, 16'd100,  16'd7,    16'd14,   5'b00000, 17);
    add("remu",        4'hB, 16'd100,  16'd7,    16'd2,    5'b00000, 17);
    add("divu_big",    4'hA, 16'hFFFF, 16'h0010, 16'h0FFF, 5'b00000, 17);
    add("divu_by0",    4'hA, 16'd5,    16'd0,    16'hFFFF, 5'b00010, 1);
    add("remu_by0",    4'hB, 16'd5,    16'd0,    16'd5,    5'b00010, 1);
`else
    add("divu_off",    4'hA, 16'd100,  16'd7,    16'd0,    5'b10001, 1);
    add("remu_off",    4'hB, 16'd100,  16'd7,    16'd0,    5'b10001, 1);
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, " result"}, 32'(ALU_Result), 32'(vecs[i].res));
      check({vecs[i].name, " flags"}, 32'({Zero, Carry, Overflow, DivZero, Illegal}),
            32'(vecs[i].flags));
      @(posedge clk);
      #1;
      check({vecs[i].name, " valid drop"}, 32'({out_valid, in_ready}), 32'b01);
    end

    // Backpressure: result must hold and new requests be ignored while out_ready is low.
    out_ready = 1'b0;
    run_op(4'h0, 16'd3, 16'd4, lat);
    check("bp latency", 32'(lat), 32'd1);
    in_valid = 1'b1; ALU_Control = 4'h6; data_1 = 16'hAAAA; data_2 = 16'h5555;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp hold", 32'({out_valid, in_ready, ALU_Result}), 32'({1'b1, 1'b0, 16'd7}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release", 32'({out_valid, in_ready, ALU_Result}), 32'({1'b0, 1'b1, 16'd7}));

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    in_valid = 1'b1; ALU_Control = 4'h8; data_1 = 16'h1234; data_2 = 16'h0100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("mid-mul busy", 32'({out_valid, in_ready}), 32'b00);
    rst = 1'b1;
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst outputs",
          32'({out_valid, ALU_Result, Zero, Carry, Overflow, DivZero, Illegal}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(4'h0, 16'd1, 16'd1, lat);
    check("post-rst add latency", 32'(lat), 32'd1);
    check("post-rst add result", 32'(ALU_Result), 32'd2);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
